// File: rtl/cv32e40p_apu_core_pkg.sv
// APU interface widths shared by the cv32e40p core and the cluster-level APU arbiter.
package cv32e40p_apu_core_pkg;

   localparam int unsigned APU_NARGS_CPU    = 3;
   localparam int unsigned APU_WOP_CPU      = 6;
   localparam int unsigned APU_NDSFLAGS_CPU = 15;
   localparam int unsigned APU_NUSFLAGS_CPU = 5;

   // Default number of requests the arbiter can have in flight at the shared unit.
   localparam int unsigned APU_ARB_MAX_OUTSTANDING_DEFAULT = 4;

   // Request payload travelling from a core to the shared unit.
   typedef struct packed {
      logic [APU_NARGS_CPU-1:0][31:0] operands;
      logic [APU_WOP_CPU-1:0]         op;
      logic [APU_NDSFLAGS_CPU-1:0]    flags;
   } apu_req_payload_t;

endpackage

// File: rtl/cv32e40p_apu_arb_id_fifo.sv
// Small register FIFO holding the IDs of granted requesters in grant order.
module cv32e40p_apu_arb_id_fifo #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DEPTH-1:0][WIDTH-1:0] mem_q;
   logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        push, pop;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign push    = push_i & ~full_o;
   assign pop     = pop_i & ~empty_o;
   assign head_o  = mem_q[rd_ptr_q];

   // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (pop && !push) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // State and storage registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= data_i;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin arbiter sharing one APU/FPU between several cv32e40p cores.
// Grant order is recorded in an ID FIFO so in-order responses return to their owners.
module cv32e40p_apu_arbiter
   import cv32e40p_apu_core_pkg::*;
#(
   parameter int unsigned NUM_CORES       = 4,
   parameter int unsigned MAX_OUTSTANDING = APU_ARB_MAX_OUTSTANDING_DEFAULT
) (
   input  logic                                          clk_i,
   input  logic                                          rst_ni,

   input  logic [NUM_CORES-1:0]                          core_apu_req_i,
   output logic [NUM_CORES-1:0]                          core_apu_gnt_o,
   input  logic [NUM_CORES-1:0][APU_NARGS_CPU-1:0][31:0] core_apu_operands_i,
   input  logic [NUM_CORES-1:0][APU_WOP_CPU-1:0]         core_apu_op_i,
   input  logic [NUM_CORES-1:0][APU_NDSFLAGS_CPU-1:0]    core_apu_flags_i,
   output logic [NUM_CORES-1:0]                          core_apu_rvalid_o,
   output logic [31:0]                                   core_apu_result_o,
   output logic [APU_NUSFLAGS_CPU-1:0]                   core_apu_flags_o,

   output logic                                          apu_req_o,
   input  logic                                          apu_gnt_i,
   output logic [APU_NARGS_CPU-1:0][31:0]                apu_operands_o,
   output logic [APU_WOP_CPU-1:0]                        apu_op_o,
   output logic [APU_NDSFLAGS_CPU-1:0]                   apu_flags_o,
   input  logic                                          apu_rvalid_i,
   input  logic [31:0]                                   apu_result_i,
   input  logic [APU_NUSFLAGS_CPU-1:0]                   apu_flags_i,

   output logic                                          busy_o,
   output logic                                          err_o
);

   localparam int unsigned ID_W = $clog2(NUM_CORES);

   apu_req_payload_t [NUM_CORES-1:0] core_payload;
   apu_req_payload_t                 apu_payload;

   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0] winner;
   logic [ID_W-1:0] head_id;
   logic            any_req;
   logic            fifo_full, fifo_empty;
   logic            handshake, pop;
   logic            err_q, err_d;

   // Cyclic index (base + off) modulo NUM_CORES.
   function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                               input int unsigned    off);
      return ID_W'((32'(base) + off) % NUM_CORES);
   endfunction

   // Per-core payload packing and one-hot grant/response decode.
   for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
      assign core_payload[g]      = '{operands: core_apu_operands_i[g],
                                      op:       core_apu_op_i[g],
                                      flags:    core_apu_flags_i[g]};
      assign core_apu_gnt_o[g]    = handshake & (winner == ID_W'(g));
      assign core_apu_rvalid_o[g] = pop & (head_id == ID_W'(g));
   end

   // First requester at or after rr_ptr, scanning cyclically.
   always_comb begin
      winner  = rr_ptr_q;
      any_req = 1'b0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         if (!any_req && core_apu_req_i[wrap_idx(rr_ptr_q, i)]) begin
            any_req = 1'b1;
            winner  = wrap_idx(rr_ptr_q, i);
         end
      end
   end

   assign apu_req_o   = any_req & ~fifo_full;
   assign handshake   = apu_req_o & apu_gnt_i;
   assign apu_payload = apu_req_o ? core_payload[winner] : '0;

   assign apu_operands_o = apu_payload.operands;
   assign apu_op_o       = apu_payload.op;
   assign apu_flags_o    = apu_payload.flags;

   // Responses are in order: the FIFO head owns the current rvalid.
   assign pop               = apu_rvalid_i & ~fifo_empty;
   assign core_apu_result_o = apu_result_i;
   assign core_apu_flags_o  = apu_flags_i;

   assign busy_o = ~fifo_empty;
   assign err_o  = err_q;

   // Round-robin pointer advances past the winner only on an accepted request.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      err_d    = err_q;
      if (handshake) begin
         rr_ptr_d = wrap_idx(winner, 1);
      end
      if (apu_rvalid_i && fifo_empty) begin
         err_d = 1'b1;
      end
   end

   // Arbiter state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q <= '0;
         err_q    <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         err_q    <= err_d;
      end
   end

   cv32e40p_apu_arb_id_fifo #(
      .WIDTH (ID_W),
      .DEPTH (MAX_OUTSTANDING)
   ) i_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (handshake),
      .data_i  (winner),
      .pop_i   (pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (head_id)
   );

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Directed bench for the shared-APU round-robin arbiter.
module tb_cv32e40p_apu_arbiter;
   import cv32e40p_apu_core_pkg::*;

   localparam int unsigned NC = 4;

   logic                                   clk_i = 1'b0;
   logic                                   rst_ni;
   logic [NC-1:0]                          core_apu_req_i;
   logic [NC-1:0]                          core_apu_gnt_o;
   logic [NC-1:0][APU_NARGS_CPU-1:0][31:0] core_apu_operands_i;
   logic [NC-1:0][APU_WOP_CPU-1:0]         core_apu_op_i;
   logic [NC-1:0][APU_NDSFLAGS_CPU-1:0]    core_apu_flags_i;
   logic [NC-1:0]                          core_apu_rvalid_o;
   logic [31:0]                            core_apu_result_o;
   logic [APU_NUSFLAGS_CPU-1:0]            core_apu_flags_o;
   logic                                   apu_req_o;
   logic                                   apu_gnt_i;
   logic [APU_NARGS_CPU-1:0][31:0]         apu_operands_o;
   logic [APU_WOP_CPU-1:0]                 apu_op_o;
   logic [APU_NDSFLAGS_CPU-1:0]            apu_flags_o;
   logic                                   apu_rvalid_i;
   logic [31:0]                            apu_result_i;
   logic [APU_NUSFLAGS_CPU-1:0]            apu_flags_i;
   logic                                   busy_o;
   logic                                   err_o;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_g [5] = '{3, 0, 1, 2, 3};

   cv32e40p_apu_arbiter #(
      .NUM_CORES       (NC),
      .MAX_OUTSTANDING (4)
   ) dut (
      .clk_i               (clk_i),
      .rst_ni              (rst_ni),
      .core_apu_req_i      (core_apu_req_i),
      .core_apu_gnt_o      (core_apu_gnt_o),
      .core_apu_operands_i (core_apu_operands_i),
      .core_apu_op_i       (core_apu_op_i),
      .core_apu_flags_i    (core_apu_flags_i),
      .core_apu_rvalid_o   (core_apu_rvalid_o),
      .core_apu_result_o   (core_apu_result_o),
      .core_apu_flags_o    (core_apu_flags_o),
      .apu_req_o           (apu_req_o),
      .apu_gnt_i           (apu_gnt_i),
      .apu_operands_o      (apu_operands_o),
      .apu_op_o            (apu_op_o),
      .apu_flags_o         (apu_flags_o),
      .apu_rvalid_i        (apu_rvalid_i),
      .apu_result_i        (apu_result_i),
      .apu_flags_i         (apu_flags_i),
      .busy_o              (busy_o),
      .err_o               (err_o)
   );

   always #5 clk_i = ~clk_i;

   // Distinct payload per core so the mux selection is visible.
   function automatic apu_req_payload_t exp_payload(input int c);
      apu_req_payload_t p;
      p.operands = {32'(4096 * (c + 1) + 2), 32'(4096 * (c + 1) + 1), 32'(4096 * (c + 1))};
      p.op       = 6'(c + 1);
      p.flags    = 15'(c + 5);
      return p;
   endfunction

   function automatic logic [3:0] oh(input int c);
      return 4'(1) << c;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_payload(input string tag, input int c, input bit en);
      apu_req_payload_t e;
      e = en ? exp_payload(c) : '0;
      check({tag, "_ops"},   128'(apu_operands_o), 128'(e.operands));
      check({tag, "_op"},    128'(apu_op_o),       128'(e.op));
      check({tag, "_flags"}, 128'(apu_flags_o),    128'(e.flags));
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_ni         = 1'b0;
      core_apu_req_i = '0;
      apu_gnt_i      = 1'b0;
      apu_rvalid_i   = 1'b0;
      apu_result_i   = '0;
      apu_flags_i    = '0;
      for (int c = 0; c < int'(NC); c++) begin
         core_apu_operands_i[2'(c)] = exp_payload(c).operands;
         core_apu_op_i[2'(c)]       = exp_payload(c).op;
         core_apu_flags_i[2'(c)]    = exp_payload(c).flags;
      end

      // Reset state
      #2;
      check("rst_gnt",    128'(core_apu_gnt_o),    128'(4'b0000));
      check("rst_rvalid", 128'(core_apu_rvalid_o), 128'(4'b0000));
      check("rst_req",    128'(apu_req_o),         128'(1'b0));
      check("rst_busy",   128'(busy_o),            128'(1'b0));
      check("rst_err",    128'(err_o),             128'(1'b0));
      check_payload("rst_pl", 0, 1'b0);
      tick();
      tick();
      rst_ni = 1'b1;
      tick();

      // Cores 0 and 2 request together; 0 then 2 granted, responses in order
      core_apu_req_i = 4'b0101;
      apu_gnt_i      = 1'b1;
      #1;
      check("t1_gnt0", 128'(core_apu_gnt_o), 128'(4'b0001));
      check("t1_req",  128'(apu_req_o),      128'(1'b1));
      check_payload("t1_pl0", 0, 1'b1);
      tick();
      core_apu_req_i = 4'b0100;
      #1;
      check("t1_gnt2", 128'(core_apu_gnt_o), 128'(4'b0100));
      check("t1_busy", 128'(busy_o),         128'(1'b1));
      check_payload("t1_pl2", 2, 1'b1);
      tick();
      core_apu_req_i = '0;
      apu_gnt_i      = 1'b0;
      #1;
      check("t1_noreq", 128'(apu_req_o), 128'(1'b0));
      check_payload("t1_plz", 0, 1'b0);
      apu_rvalid_i = 1'b1;
      apu_result_i = 32'hA;
      apu_flags_i  = 5'h3;
      #1;
      check("t1_rv0",  128'(core_apu_rvalid_o), 128'(4'b0001));
      check("t1_res0", 128'(core_apu_result_o), 128'(32'hA));
      check("t1_fl0",  128'(core_apu_flags_o),  128'(5'h3));
      tick();
      apu_result_i = 32'hB;
      apu_flags_i  = 5'h4;
      #1;
      check("t1_rv2",  128'(core_apu_rvalid_o), 128'(4'b0100));
      check("t1_res2", 128'(core_apu_result_o), 128'(32'hB));
      tick();
      apu_rvalid_i = 1'b0;
      #1;
      check("t1_idle", 128'(busy_o), 128'(1'b0));
      check("t1_err",  128'(err_o),  128'(1'b0));

      // All cores request, one response per cycle; pointer currently 3
      core_apu_req_i = 4'b1111;
      apu_gnt_i      = 1'b1;
      for (int i = 0; i < 5; i++) begin
         apu_rvalid_i = (i > 0);
         #1;
         check($sformatf("t2_gnt%0d", i), 128'(core_apu_gnt_o), 128'(oh(exp_g[i])));
         check($sformatf("t2_rv%0d", i), 128'(core_apu_rvalid_o),
               128'((i > 0) ? oh(exp_g[(i > 0) ? i - 1 : 0]) : 4'b0000));
         if (i > 0) check($sformatf("t2_busy%0d", i), 128'(busy_o), 128'(1'b1));
         tick();
      end
      core_apu_req_i = '0;
      apu_rvalid_i   = 1'b1;
      #1;
      check("t2_rvlast", 128'(core_apu_rvalid_o), 128'(4'b1000));
      tick();
      apu_rvalid_i = 1'b0;
      #1;
      check("t2_idle", 128'(busy_o), 128'(1'b0));
      check("t2_err",  128'(err_o),  128'(1'b0));

      // Fill the FIFO with core 1, then observe back-pressure and release
      core_apu_req_i = 4'b0010;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("t3_gnt%0d", i), 128'(core_apu_gnt_o), 128'(4'b0010));
         tick();
      end
      #1;
      check("t3_full_req", 128'(apu_req_o),      128'(1'b0));
      check("t3_full_gnt", 128'(core_apu_gnt_o), 128'(4'b0000));
      check_payload("t3_full_pl", 0, 1'b0);
      tick();
      apu_rvalid_i = 1'b1;
      #1;
      check("t3_pop_rv",  128'(core_apu_rvalid_o), 128'(4'b0010));
      check("t3_pop_req", 128'(apu_req_o),         128'(1'b0));
      check("t3_pop_gnt", 128'(core_apu_gnt_o),    128'(4'b0000));
      tick();
      apu_rvalid_i = 1'b0;
      #1;
      check("t3_regnt", 128'(core_apu_gnt_o), 128'(4'b0010));
      tick();
      core_apu_req_i = '0;
      apu_rvalid_i   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("t3_drain%0d", i), 128'(core_apu_rvalid_o), 128'(4'b0010));
         tick();
      end
      apu_rvalid_i = 1'b0;
      #1;
      check("t3_idle", 128'(busy_o), 128'(1'b0));

      // Stalled grant: pointer at 2 keeps core 3 ahead of core 1 until accepted
      core_apu_req_i = 4'b1010;
      apu_gnt_i      = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check($sformatf("t4_req%0d", i),  128'(apu_req_o),      128'(1'b1));
         check($sformatf("t4_gnt%0d", i),  128'(core_apu_gnt_o), 128'(4'b0000));
         check($sformatf("t4_busy%0d", i), 128'(busy_o),         128'(1'b0));
         check_payload($sformatf("t4_pl%0d", i), 3, 1'b1);
         tick();
      end
      apu_gnt_i = 1'b1;
      #1;
      check("t4_gnt3", 128'(core_apu_gnt_o), 128'(4'b1000));
      tick();
      core_apu_req_i = 4'b0010;
      #1;
      check("t4_gnt1", 128'(core_apu_gnt_o), 128'(4'b0010));
      check("t4_busy", 128'(busy_o),         128'(1'b1));
      tick();
      core_apu_req_i = '0;
      apu_gnt_i      = 1'b0;
      apu_rvalid_i   = 1'b1;
      #1;
      check("t4_rv3", 128'(core_apu_rvalid_o), 128'(4'b1000));
      tick();
      check("t4_rv1", 128'(core_apu_rvalid_o), 128'(4'b0010));
      tick();
      apu_rvalid_i = 1'b0;
      #1;
      check("t4_idle", 128'(busy_o), 128'(1'b0));

      // Stray response at idle sets the sticky error
      rst_ni = 1'b0;
      #2;
      rst_ni = 1'b1;
      tick();
      apu_rvalid_i = 1'b1;
      apu_result_i = 32'h55;
      #1;
      check("t5_rv",      128'(core_apu_rvalid_o), 128'(4'b0000));
      check("t5_err_pre", 128'(err_o),             128'(1'b0));
      tick();
      apu_rvalid_i = 1'b0;
      #1;
      check("t5_err_set", 128'(err_o), 128'(1'b1));
      tick();
      tick();
      check("t5_err_hold", 128'(err_o),  128'(1'b1));
      check("t5_busy",     128'(busy_o), 128'(1'b0));

      // Reset with two outstanding requests clears everything asynchronously
      core_apu_req_i = 4'b0100;
      apu_gnt_i      = 1'b1;
      #1;
      check("t6_gnt2", 128'(core_apu_gnt_o), 128'(4'b0100));
      tick();
      core_apu_req_i = 4'b0001;
      #1;
      check("t6_gnt0", 128'(core_apu_gnt_o), 128'(4'b0001));
      tick();
      core_apu_req_i = '0;
      apu_gnt_i      = 1'b0;
      #1;
      check("t6_busy_pre", 128'(busy_o), 128'(1'b1));
      check("t6_err_pre",  128'(err_o),  128'(1'b1));
      rst_ni = 1'b0;
      #1;
      check("t6_busy_rst", 128'(busy_o), 128'(1'b0));
      check("t6_err_rst",  128'(err_o),  128'(1'b0));
      tick();
      rst_ni = 1'b1;
      tick();
      core_apu_req_i = 4'b0011;
      apu_gnt_i      = 1'b1;
      #1;
      check("t6_gnt_after", 128'(core_apu_gnt_o), 128'(4'b0001));
      tick();
      core_apu_req_i = '0;
      apu_gnt_i      = 1'b0;
      apu_rvalid_i   = 1'b1;
      apu_result_i   = 32'hC;
      #1;
      check("t6_rv0",  128'(core_apu_rvalid_o), 128'(4'b0001));
      check("t6_res0", 128'(core_apu_result_o), 128'(32'hC));
      tick();
      apu_rvalid_i = 1'b0;
      #1;
      check("t6_idle", 128'(busy_o), 128'(1'b0));
      check("t6_err",  128'(err_o),  128'(1'b0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
